// File: rtl/shift_sequencer_if.sv
// Command and shift-register control bundle between a command source and the sequencer.
interface shift_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [N-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             load;
  logic             shift_left;
  logic             shift_right;
  logic [N-1:0]     in_data;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    input  cmd_ready, load, shift_left, shift_right, in_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    output cmd_ready, load, shift_left, shift_right, in_data, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven sequencer generating load / shift strobes for an N-bit
// bidirectional shift register. One command at a time, done pulse per command.
module shift_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  shift_sequencer_if.slave    bus
);
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       op, op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] k;
  logic             accept;
  logic             is_shift_cmd;

  logic             load_r, shl_r, shr_r, done_r;
  logic             load_nx, shl_nx, shr_nx, done_nx;
  logic [N-1:0]     in_data_r, in_data_nx;

  // Effective shift distance saturates at the register width.
  assign k            = (bus.cmd_count > CNT_W'(N)) ? CNT_W'(N) : bus.cmd_count;
  assign accept       = bus.cmd_valid && (state == IDLE);
  assign is_shift_cmd = (bus.cmd_op == OP_SHL) || (bus.cmd_op == OP_SHR);

  // State, latched opcode and remaining strobe count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op    <= 2'b11;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: loads take one RUN cycle, shifts take k RUN cycles unless aborted.
  always_comb begin
    state_nx = state;
    op_nx    = op;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nx  = bus.cmd_op;
          cnt_nx = is_shift_cmd ? k : '0;
          if (bus.cmd_op == OP_LOAD || (is_shift_cmd && k != '0))
            state_nx = RUN;
          else
            state_nx = DONE;
        end
      end
      RUN: begin
        if (op == OP_LOAD) begin
          state_nx = DONE;
        end else if (bus.abort || cnt == CNT_W'(1)) begin
          // The strobe visible this cycle is the last one delivered.
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered, so they
  // line up cycle-for-cycle with that state.
  always_comb begin
    load_nx    = (state_nx == RUN) && (op_nx == OP_LOAD);
    shl_nx     = (state_nx == RUN) && (op_nx == OP_SHL);
    shr_nx     = (state_nx == RUN) && (op_nx == OP_SHR);
    done_nx    = (state_nx == DONE);
    in_data_nx = (accept && bus.cmd_op == OP_LOAD) ? bus.cmd_data : in_data_r;
  end

  // Output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_r    <= 1'b0;
      shl_r     <= 1'b0;
      shr_r     <= 1'b0;
      done_r    <= 1'b0;
      in_data_r <= '0;
    end else begin
      load_r    <= load_nx;
      shl_r     <= shl_nx;
      shr_r     <= shr_nx;
      done_r    <= done_nx;
      in_data_r <= in_data_nx;
    end
  end

  assign bus.load        = load_r;
  assign bus.shift_left  = shl_r;
  assign bus.shift_right = shr_r;
  assign bus.done        = done_r;
  assign bus.in_data     = in_data_r;
  assign bus.cmd_ready   = (state == IDLE) && !reset;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, randomized commands against
// a command-level model of the downstream register, and reset corner cases.
module tb_shift_sequencer;
  localparam int N = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();
  shift_sequencer #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Emulated downstream shift register (zero fill).
  logic [7:0] q_ds = 8'h00;
  always @(posedge clk) begin
    if (bus.load)             q_ds <= bus.in_data;
    else if (bus.shift_left)  q_ds <= q_ds << 1;
    else if (bus.shift_right) q_ds <= q_ds >> 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ab > 0: raise abort in the cycle where the ab-th strobe is visible.
  // ab < 0: hold abort high for the whole command.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                        input int ab, output int nld, output int nsl, output int nsr,
                        output int dcyc, output int viol);
    nld = 0; nsl = 0; nsr = 0; dcyc = -1; viol = 0;
    @(negedge clk);
    check("ready_before_cmd", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data; bus.cmd_count = cnt;
    bus.abort = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_data = 8'($urandom); bus.cmd_count = 4'($urandom);
    if (ab < 0) bus.abort = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.load) nld++;
      if (bus.shift_left) nsl++;
      if (bus.shift_right) nsr++;
      if (int'(bus.load) + int'(bus.shift_left) + int'(bus.shift_right) > 1) viol++;
      if (bus.done && (bus.load || bus.shift_left || bus.shift_right)) viol++;
      if (!bus.busy || bus.cmd_ready) viol++;
      if (ab > 0) bus.abort = ((nsl + nsr) == ab);
      if (bus.done) begin dcyc = c; break; end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", int'(bus.cmd_ready), 1);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [3:0] cnt;
    int         ab;
    int         e_ld, e_sl, e_sr, e_dcyc;
    logic [7:0] e_q, e_ind;
  } vec_t;

  vec_t tbl[11];
  int nld, nsl, nsr, dcyc, viol;

  initial begin
    logic [7:0] qm, indm;
    int k, dlv, ab, seen;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_data = 8'h00;
    bus.cmd_count = 4'h0; bus.abort = 1'b0;

    //         op     data   cnt ab  ld sl sr dcyc q      in_data
    tbl[0]  = '{2'b00, 8'hAA, 0,  0,  1, 0, 0, 2, 8'hAA, 8'hAA};
    tbl[1]  = '{2'b01, 8'h00, 3,  0,  0, 3, 0, 4, 8'h50, 8'hAA};
    tbl[2]  = '{2'b00, 8'hFF, 0,  0,  1, 0, 0, 2, 8'hFF, 8'hFF};
    tbl[3]  = '{2'b10, 8'h11, 12, 0,  0, 0, 8, 9, 8'h00, 8'hFF};
    tbl[4]  = '{2'b10, 8'h22, 0,  0,  0, 0, 0, 1, 8'h00, 8'hFF};
    tbl[5]  = '{2'b11, 8'h33, 5,  0,  0, 0, 0, 1, 8'h00, 8'hFF};
    tbl[6]  = '{2'b00, 8'h80, 0,  0,  1, 0, 0, 2, 8'h80, 8'h80};
    tbl[7]  = '{2'b10, 8'h44, 5,  2,  0, 0, 2, 3, 8'h20, 8'h80};
    tbl[8]  = '{2'b00, 8'h3C, 0, -1,  1, 0, 0, 2, 8'h3C, 8'h3C};
    tbl[9]  = '{2'b01, 8'h55, 8, -1,  0, 1, 0, 2, 8'h78, 8'h3C};
    tbl[10] = '{2'b01, 8'h66, 15, 0,  0, 8, 0, 9, 8'h00, 8'h3C};

    // Reset state
    #12;
    check("rst_ready", int'(bus.cmd_ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_strobes", int'(bus.load) + int'(bus.shift_left) + int'(bus.shift_right), 0);
    check("rst_in_data", int'(bus.in_data), 0);
    @(negedge clk); reset = 1'b0;
    #1;
    check("post_rst_ready", int'(bus.cmd_ready), 1);

    // Directed vectors
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].data, tbl[i].cnt, tbl[i].ab, nld, nsl, nsr, dcyc, viol);
      check($sformatf("v%0d_load", i), nld, tbl[i].e_ld);
      check($sformatf("v%0d_shl", i), nsl, tbl[i].e_sl);
      check($sformatf("v%0d_shr", i), nsr, tbl[i].e_sr);
      check($sformatf("v%0d_done_cyc", i), dcyc, tbl[i].e_dcyc);
      check($sformatf("v%0d_q", i), int'(q_ds), int'(tbl[i].e_q));
      check($sformatf("v%0d_in_data", i), int'(bus.in_data), int'(tbl[i].e_ind));
      check($sformatf("v%0d_invariant", i), viol, 0);
    end

    // Randomized commands against a command-level model
    qm = tbl[10].e_q; indm = tbl[10].e_ind;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op; logic [7:0] d; logic [3:0] c;
      op = 2'($urandom_range(0, 3)); d = 8'($urandom); c = 4'($urandom_range(0, 15));
      k = (int'(c) > N) ? N : int'(c);
      ab = 0;
      if ((op == 2'b01 || op == 2'b10) && k > 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, k);
      else if ($urandom_range(0, 5) == 0 && op != 2'b01 && op != 2'b10)
        ab = -1;
      do_cmd(op, d, c, ab, nld, nsl, nsr, dcyc, viol);
      dlv = (op == 2'b01 || op == 2'b10) ? ((ab > 0) ? ab : k) : 0;
      if (op == 2'b00) begin qm = d; indm = d; end
      else if (op == 2'b01) qm = qm << dlv;
      else if (op == 2'b10) qm = qm >> dlv;
      check($sformatf("r%0d_load", i), nld, (op == 2'b00) ? 1 : 0);
      check($sformatf("r%0d_shl", i), nsl, (op == 2'b01) ? dlv : 0);
      check($sformatf("r%0d_shr", i), nsr, (op == 2'b10) ? dlv : 0);
      check($sformatf("r%0d_done_cyc", i), dcyc, (op == 2'b00) ? 2 : dlv + 1);
      check($sformatf("r%0d_q", i), int'(q_ds), int'(qm));
      check($sformatf("r%0d_in_data", i), int'(bus.in_data), int'(indm));
      check($sformatf("r%0d_invariant", i), viol, 0);
    end

    // Reset during the 3rd of 5 shift-left strobes
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_count = 4'd5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      if (bus.shift_left) seen++;
      if (seen < 3) begin @(posedge clk); #1; end
    end
    check("mid_rst_reached_3rd", seen, 3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_shl", int'(bus.shift_left), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_ready", int'(bus.cmd_ready), 0);
    check("mid_rst_in_data", int'(bus.in_data), 0);
    check("mid_rst_done", int'(bus.done), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", int'(bus.done), 0);
    end
    @(negedge clk); reset = 1'b0;
    #1;
    check("rel_ready", int'(bus.cmd_ready), 1);
    check("rel_busy", int'(bus.busy), 0);
    do_cmd(2'b00, 8'h0F, 4'd0, 0, nld, nsl, nsr, dcyc, viol);
    check("rel_load_cnt", nld, 1);
    check("rel_done_cyc", dcyc, 2);
    check("rel_q", int'(q_ds), 8'h0F);
    check("rel_in_data", int'(bus.in_data), 8'h0F);
    check("rel_invariant", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sits directly upstream of the N-bit bidirectional shift register and generates its load, shift_left, shift_right and in_data inputs. It accepts one command at a time over a valid/ready handshake. Each command is a parallel load, a multi-cycle shift of up to N positions in either direction, or a no-op. It reports busy and a one-cycle done pulse, and supports a synchronous abort of a running shift.

Parameters:
N, 8, data width; must match the downstream shift register width.
CNT_W, 4, width of cmd_count; 2^CNT_W-1 >= N is required.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 load, 01 shift left, 10 shift right, 11 no-op
cmd_data  input  N  parallel data for load op
cmd_count  input  CNT_W  shift distance for shift ops
abort  input  1  synchronous stop of a running shift
load  output  1  to shift register load
shift_left  output  1  to shift register shift_left
shift_right  output  1  to shift register shift_right
in_data  output  N  to shift register in_data
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All outputs are registered except cmd_ready and busy, which are decoded from the state.
- Reset (async, takes effect immediately, including mid-command): state IDLE; load, shift_left, shift_right and done go to 0; in_data goes to 0; the remaining count clears. While reset is high, cmd_ready=0.
- States: IDLE, RUN, DONE.
  - cmd_ready=1 only in IDLE with reset low.
  - busy=1 in RUN and DONE.
- Acceptance: a command is accepted at an edge T where cmd_valid && cmd_ready. Command fields are sampled only at acceptance. cmd_valid is ignored outside IDLE.
- Load op:
  - in_data <= cmd_data at T and holds until the next accepted load (shift and no-op commands do not change it).
  - load=1 during cycle T..T+1 only. State goes RUN then DONE.
  - Sequence: accept at T; load high in cycle after T; done high in the following cycle; IDLE (cmd_ready=1) one cycle later.
- Shift ops:
  - Effective count k = min(cmd_count, N).
  - If k>0: the matching strobe (shift_left for 01, shift_right for 10) is high for exactly k consecutive cycles starting in the cycle after T. done is high in the cycle after the last strobe, then IDLE.
  - If k=0: no strobe; done is high in the cycle after T (state goes directly to DONE).
- No-op (11): treated as k=0; no strobes, no in_data change.
- Invariant: at most one of load, shift_left, shift_right is high in any cycle. done is never high together with any strobe.
- Abort:
  - Sampled only in RUN during a shift op. If abort=1 at an edge, the strobe driven after that edge is 0 and the state goes to DONE.
  - Strobes already high in the cycle where abort is sampled count as delivered; the downstream register sees them on that same edge.
  - abort is ignored in IDLE and DONE, and during a load op.
- Counter: CNT_W-bit down-counter loaded with k at acceptance, decremented per strobe cycle. No wrap; RUN exits when the counter reaches the final strobe.
- done: exactly one cycle per accepted command, including k=0, no-op and aborted commands.

Test Plan:
- Reset: assert reset mid-bench -> all outputs 0 and in_data=0 immediately; after deassert, cmd_ready=1, busy=0.
- Load 8'hAA: accept at T -> load=1 for one cycle after T, in_data=8'hAA, done one cycle later; downstream q=8'hAA; cmd_ready returns the following cycle.
- After load 8'hAA, shift left count 3 -> shift_left high 3 consecutive cycles, then done; q=8'h50; in_data still 8'hAA.
- After load 8'hFF, shift right count 12 -> saturates to 8 strobes, done, q=8'h00. Count 0 and no-op each give no strobe and done in the cycle after accept.
- After load 8'h80, shift right count 5 with abort high during the 2nd strobe cycle -> exactly 2 strobes, q=8'h20, done next cycle, then IDLE.
- Reset asserted during the 3rd of 5 shift-left strobes -> strobe drops immediately, busy=0, no done pulse. After release, a new load of 8'h0F completes normally.
